// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - SB_PLL40 reset/lock sequencer with retry, lock qualification and ready flag
// Runs on the PLL reference clock; all outputs decode from registered state.
module pll_lock_ctrl #(
  parameter int RESET_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_W        = 4,
  parameter bit BYPASS_ON_FAIL = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               ready,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retries,
  output logic [2:0]         state
);

  localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retries_q;
  logic               lock_lost_q;
  logic               lock_m;
  logic               lock_s;

  // LOCK is asynchronous to clk; only lock_s is used downstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // cnt is free-running in RUN/FAIL; nothing looks at it there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HOLD;
      cnt         <= '0;
      retries_q   <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        cnt         <= '0;
        retries_q   <= '0;
        lock_lost_q <= 1'b0;
      end else begin
        cnt <= (state_d != state_q) ? '0 : cnt + CNT_W'(1);
        if (state_q == S_WAIT_LOCK && state_d == S_HOLD)
          retries_q <= retries_q + RETRY_W'(1);
        else if (state_q == S_STABLE && state_d == S_RUN)
          retries_q <= '0;
        if (state_q == S_RUN && !lock_s)
          lock_lost_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (cnt == RESET_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s)
          state_d = S_STABLE;
        else if (cnt == TIMEOUT_LAST)
          state_d = (retries_q == RETRY_LIMIT) ? S_FAIL : S_HOLD;
      end
      S_STABLE: begin
        if (!lock_s)
          state_d = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) state_d = S_HOLD;
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_HOLD;
    endcase
    if (restart) state_d = S_HOLD;
  end

  always_comb begin
    pll_resetb = 1'b0;
    pll_bypass = 1'b0;
    ready      = 1'b0;
    fail       = 1'b0;
    case (state_q)
      S_WAIT_LOCK, S_STABLE: pll_resetb = 1'b1;
      S_RUN: begin
        pll_resetb = 1'b1;
        ready      = 1'b1;
      end
      S_FAIL: begin
        fail       = 1'b1;
        pll_bypass = BYPASS_ON_FAIL;
      end
      default: ;
    endcase
  end

  assign retries   = retries_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - scoreboard bench for pll_lock_ctrl
// Stimulus pushes timestamped expected output snapshots; a negedge monitor pops one per output change.
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retries;
  logic [2:0] state;

  pll_lock_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .RETRY_W       (4),
    .BYPASS_ON_FAIL(1'b1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_resetb(pll_resetb),
    .pll_bypass(pll_bypass),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retries   (retries),
    .state     (state)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] HOLD = 3'd0, WAIT = 3'd1, STAB = 3'd2, RUN = 3'd3, FL = 3'd4;

  typedef struct {
    int          cyc;
    logic [11:0] v;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] prev;

  always @(posedge clk) cyc++;

  // Expected outputs for a state, straight from the decode rules.
  function automatic logic [11:0] expv(input logic [2:0] st, input logic [3:0] rt, input logic ll);
    logic rb, byp, rdy, fl;
    rb  = (st == WAIT) || (st == STAB) || (st == RUN);
    byp = (st == FL);
    rdy = (st == RUN);
    fl  = (st == FL);
    return {st, rb, byp, rdy, fl, ll, rt};
  endfunction

  function automatic logic [11:0] snap();
    return {state, pll_resetb, pll_bypass, ready, fail, lock_lost, retries};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dly, input logic [2:0] st, input logic [3:0] rt, input logic ll);
    exp_t e;
    e.cyc = cyc + dly;
    e.v   = expv(st, rt, ll);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial prev = expv(HOLD, 4'd0, 1'b0);

  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t        e;
    cur = snap();
    if (cur !== prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_change", int'(cur), int'(prev));
      end else begin
        e = sb.pop_front();
        chk("snapshot", int'(cur), int'(e.v));
        chk("change_cycle", cyc, e.cyc);
      end
      prev = cur;
    end
  end

  initial begin
    resetn   = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    step(3);
    chk("reset_state", int'(snap()), int'(expv(HOLD, 4'd0, 1'b0)));

    // Bring-up: resetb rises on edge 4, lock 10 cycles later, ready 11 edges after lock.
    resetn = 1'b1;
    push(4, WAIT, 4'd0, 1'b0);
    step(14);
    pll_lock = 1'b1;
    push(3, STAB, 4'd0, 1'b0);
    push(11, RUN, 4'd0, 1'b0);
    step(15);

    // Lock drop in RUN: ready falls 3 edges later, lock_lost sticks through relock.
    pll_lock = 1'b0;
    push(3, HOLD, 4'd0, 1'b1);
    push(7, WAIT, 4'd0, 1'b1);
    step(10);
    pll_lock = 1'b1;
    push(3, STAB, 4'd0, 1'b1);
    push(11, RUN, 4'd0, 1'b1);
    step(15);

    // Restart clears lock_lost; then a one-cycle lock glitch at STABLE cnt=5.
    restart = 1'b1;
    push(1, HOLD, 4'd0, 1'b0);
    push(5, WAIT, 4'd0, 1'b0);
    push(6, STAB, 4'd0, 1'b0);
    step(1);
    restart = 1'b0;
    step(8);
    pll_lock = 1'b0;
    push(3, WAIT, 4'd0, 1'b0);
    push(4, STAB, 4'd0, 1'b0);
    push(12, RUN, 4'd0, 1'b0);
    step(1);
    pll_lock = 1'b1;
    step(15);

    // Async reset mid-RUN.
    resetn = 1'b0;
    push(0, HOLD, 4'd0, 1'b0);
    #1;
    chk("async_reset_run", int'(snap()), int'(expv(HOLD, 4'd0, 1'b0)));
    step(2);
    resetn = 1'b1;
    push(4, WAIT, 4'd0, 1'b0);
    push(5, STAB, 4'd0, 1'b0);
    step(8);

    // Async reset mid-STABLE, then lock stays low for the retry sequence.
    resetn   = 1'b0;
    pll_lock = 1'b0;
    push(0, HOLD, 4'd0, 1'b0);
    #1;
    chk("async_reset_stable", int'(snap()), int'(expv(HOLD, 4'd0, 1'b0)));
    chk("async_resetb_low", int'(pll_resetb), 0);
    step(2);
    resetn = 1'b1;
    push(4, WAIT, 4'd0, 1'b0);
    push(36, HOLD, 4'd1, 1'b0);
    push(40, WAIT, 4'd1, 1'b0);
    push(72, HOLD, 4'd2, 1'b0);
    push(76, WAIT, 4'd2, 1'b0);
    push(108, FL, 4'd2, 1'b0);
    step(110);
    chk("fail_flag", int'(fail), 1);
    chk("fail_bypass", int'(pll_bypass), 1);

    // Restart out of FAIL with lock present.
    pll_lock = 1'b1;
    step(3);
    restart = 1'b1;
    push(1, HOLD, 4'd0, 1'b0);
    push(5, WAIT, 4'd0, 1'b0);
    push(6, STAB, 4'd0, 1'b0);
    push(14, RUN, 4'd0, 1'b0);
    step(1);
    restart = 1'b0;
    step(15);

    // Restart held 3 cycles; lock arrives on the timeout cycle and wins.
    restart  = 1'b1;
    pll_lock = 1'b0;
    push(1, HOLD, 4'd0, 1'b0);
    push(7, WAIT, 4'd0, 1'b0);
    push(39, STAB, 4'd0, 1'b0);
    push(47, RUN, 4'd0, 1'b0);
    step(3);
    restart = 1'b0;
    step(33);
    pll_lock = 1'b1;
    step(15);

    for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
    step(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
